// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM encoding for the multiply/divide ALU and its control decoder.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_MULT = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: one bit per cycle shift-add multiply or restoring divide.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_nxt_o,
    output logic [WIDTH-1:0] lo_nxt_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;

    // hi holds the partial product (multiply) or running remainder (divide)
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, b_q};
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (div_q) begin
            if (!div_diff[WIDTH]) begin
                hi_d = div_diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = div_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            hi_q  <= '0;
            lo_q  <= a_i;
            b_q   <= b_i;
            div_q <= div_i;
            cnt_q <= CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign last_o   = (cnt_q == CNT_W'(1));
    assign hi_nxt_o = hi_d;
    assign lo_nxt_o = lo_d;

endmodule

// File: rtl/muldiv_alu.sv
// Single-cycle logic/arith/compare ALU with an iterative MULT/DIV unit behind an IDLE/RUN/DONE sequencer.
module muldiv_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [3:0]       ALUCtr,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic [WIDTH-1:0] Res,
    output logic             Zero,
    output logic             Overflow,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, lo_q, lo_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] alu_res, sum, dif;
    logic             alu_ovf;
    logic             accept, div_zero, iter_load, iter_last;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    assign accept    = (state_q == ST_IDLE) && Start;
    assign div_zero  = (ALUCtr == OP_DIV) && (In2 == '0);
    assign iter_load = accept && is_iter_op(ALUCtr) && !div_zero;

    muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (iter_load),
        .div_i    (ALUCtr == OP_DIV),
        .a_i      (In1),
        .b_i      (In2),
        .last_o   (iter_last),
        .hi_nxt_o (iter_hi),
        .lo_nxt_o (iter_lo)
    );

    always_comb begin
        sum     = In1 + In2;
        dif     = In1 - In2;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUCtr)
            OP_AND:  alu_res = In1 & In2;
            OP_OR:   alu_res = In1 | In2;
            OP_NOR:  alu_res = ~(In1 | In2);
            OP_XOR:  alu_res = In1 ^ In2;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (In1[WIDTH-1] == In2[WIDTH-1]) && (sum[WIDTH-1] != In1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif;
                alu_ovf = (In1[WIDTH-1] != In2[WIDTH-1]) && (dif[WIDTH-1] != In1[WIDTH-1]);
            end
            OP_SLTU: alu_res = WIDTH'(In1 < In2);
            OP_SLT:  alu_res = WIDTH'($signed(In1) < $signed(In2));
            OP_DIV:  alu_res = '1;  // only reached for divide-by-zero
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        res_d  = res_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (accept && !iter_load) begin
            res_d  = alu_res;
            zero_d = (alu_res == '0);
            ovf_d  = alu_ovf;
            if (div_zero) begin
                hi_d = In1;
                lo_d = '1;
            end
        end else if ((state_q == ST_RUN) && iter_last) begin
            res_d  = iter_lo;
            zero_d = (iter_lo == '0);
            ovf_d  = 1'b0;
            hi_d   = iter_hi;
            lo_d   = iter_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b1;
            ovf_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            res_q  <= res_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (Start) state_d = iter_load ? ST_RUN : ST_DONE;
            ST_RUN:  if (iter_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy = (state_q == ST_RUN);
        Done = (state_q == ST_DONE);
    end

    assign Res      = res_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;
    assign Hi       = hi_q;
    assign Lo       = lo_q;

endmodule

// File: doc/muldiv_alu.md
MULDIV_ALU -- requirements
Module: muldiv_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (>=4, even).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port Start, input, 1, request pulse; sampled only in IDLE.
REQ-006 SHALL have port ALUCtr, input, 4, operation select, sampled with Start.
REQ-007 SHALL have ports In1 and In2, input, WIDTH, operands, sampled with Start.
REQ-008 SHALL have port Res, output, WIDTH, registered primary result.
REQ-009 SHALL have port Zero, output, 1, registered, high when Res == 0.
REQ-010 SHALL have port Overflow, output, 1, registered signed overflow for ADD/SUB, else 0.
REQ-011 SHALL have ports Hi and Lo, output, WIDTH, registered MULT/DIV results.
REQ-012 SHALL have port Busy, output, 1, high while an iterative operation runs.
REQ-013 SHALL have port Done, output, 1, single-cycle pulse marking Res/Zero/Overflow/Hi/Lo valid.

Function
REQ-014 SHALL decode ALUCtr: 0000 AND, 0101 OR, 1100 NOR, 1101 XOR, 0010 ADD, 0110 SUB, 0111 SLTU (unsigned), 1000 SLT (signed), 1001 MULT (unsigned), 1010 DIV (unsigned).
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; IDLE->DONE on Start with single-cycle op or DIV by zero; IDLE->RUN on Start with MULT/DIV; RUN->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-016 SHALL, for single-cycle ops, register Res on the Start edge and assert Done the following cycle (latency 1).
REQ-017 SHALL, for MULT/DIV, run exactly WIDTH iterations (shift-add; restoring divide) and assert Done WIDTH+1 cycles after the Start edge.
REQ-018 SHALL set MULT result {Hi,Lo} = 2*WIDTH-bit product, Res = Lo.
REQ-019 SHALL set DIV results Lo = quotient, Hi = remainder, Res = Lo.
REQ-020 SHALL, for DIV with In2 == 0, skip RUN and produce Lo = all ones, Hi = In1, Res = all ones, Done at latency 1.
REQ-021 SHALL hold Hi/Lo unchanged on non-MULT/DIV ops; SHALL hold Res/Hi/Lo after Done until the next accepted operation.
REQ-022 SHALL wrap ADD/SUB modulo 2^WIDTH; Overflow = signed overflow of the operation.
REQ-023 SHALL set SLT/SLTU Res to 1 or 0, zero-extended to WIDTH.
REQ-024 SHALL treat undefined ALUCtr codes as single-cycle ops giving Res = 0, Zero = 1, Overflow = 0.
REQ-025 SHALL ignore Start in RUN and DONE (no queuing, operands not resampled).
REQ-026 SHALL drive Busy = 1 exactly in RUN; Busy and Done never both high.
REQ-027 SHALL compute Zero from the registered Res, valid with Done.

Reset
REQ-028 SHALL, when rst_n is low at a rising edge, set state IDLE and Res, Hi, Lo, counter, internal operands to 0, Zero = 1, Overflow = 0, Busy = 0, Done = 0.
REQ-029 SHALL let reset abort an in-flight MULT/DIV with no Done pulse issued.
REQ-030 SHALL give reset priority over a simultaneous Start.

Structure
REQ-031 SHALL place ALUCtr opcode constants and the FSM state encoding in shared package alu_pkg for reuse by the control decoder.
REQ-032 SHALL implement the iterative datapath (shift-add/restoring-divide, counter) as sub-module muldiv_iter; logic ops, ADD/SUB, compare, and FSM stay in muldiv_alu.

Verification (WIDTH=32)
REQ-033 SHALL cover ADD 0x7FFFFFFF + 0x00000001 -> Res 0x80000000, Overflow 1, Zero 0, Done 1 cycle after Start.
REQ-034 SHALL cover MULT 0xFFFFFFFF * 0x00000002 -> Hi 0x00000001, Lo 0xFFFFFFFE, Busy 32 cycles, Done exactly 33 cycles after Start.
REQ-035 SHALL cover DIV 100 / 7 -> Lo 14, Hi 2 at latency 33; DIV 5 / 0 -> Lo 0xFFFFFFFF, Hi 5, latency 1.
REQ-036 SHALL cover Start pulsed with SUB 1,1 during a running MULT -> ignored; MULT result intact, one Done only.
REQ-037 SHALL cover rst_n low 10 cycles into a MULT -> next cycle all outputs at reset values, no Done, then SUB 5 - 5 -> Res 0, Zero 1.
REQ-038 SHALL cover SLT 0xFFFFFFFF, 0x00000001 -> Res 1; SLTU same operands -> Res 0.
